// File: rtl/cpld_pid_regfile.sv
// rtl/cpld_pid_regfile.sv - PC104 register file for double-buffered PID gains and mode selects
module cpld_pid_regfile #(
    parameter int DATA_W = 8,
    parameter int NCH    = 2,
    parameter int ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     bus_addr,
    input  logic [DATA_W-1:0]     bus_din,
    input  logic                  bus_wr_n,
    input  logic                  bus_rd_n,
    output logic [DATA_W-1:0]     bus_dout,
    output logic                  bus_oe,
    output logic [NCH*DATA_W-1:0] pid_gain,
    output logic                  mode_stm,
    output logic                  mode_afm_tp,
    output logic                  mode_afm_cn,
    output logic                  upd_pulse
);

    localparam logic [ADDR_W-1:0] ADDR_MODE   = ADDR_W'(4'hC);
    localparam logic [ADDR_W-1:0] ADDR_COMMIT = ADDR_W'(4'hD);
    localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(4'hE);
    localparam logic [ADDR_W-1:0] ADDR_CLRERR = ADDR_W'(4'hF);

    // wr_s[0], wr_s[1] are the synchronizer stages, wr_s[2] is the edge-detect history
    logic [2:0]        wr_s;
    logic [ADDR_W-1:0] addr_s1, addr_s2;
    logic [DATA_W-1:0] din_s1, din_s2;
    logic              wr_rise;

    logic              wr_stb;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;

    logic [NCH-1:0][DATA_W-1:0] shadow;
    logic [NCH-1:0][DATA_W-1:0] active;
    logic [2:0]                 mode;
    logic                       err;
    logic                       pending;
    logic                       mode_ok;

    assign wr_rise = wr_s[1] & ~wr_s[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_s      <= 3'b111;
            addr_s1   <= '0;
            addr_s2   <= '0;
            din_s1    <= '0;
            din_s2    <= '0;
            wr_stb    <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_s    <= {wr_s[1:0], bus_wr_n};
            addr_s1 <= bus_addr;
            addr_s2 <= addr_s1;
            din_s1  <= bus_din;
            din_s2  <= din_s1;
            // One extra register stage so the target lands on the third edge after sampling
            wr_stb  <= wr_rise;
            if (wr_rise) begin
                wr_addr_q <= addr_s2;
                wr_data_q <= din_s2;
            end
        end
    end

    always_comb begin
        mode_ok = 1'b0;
        case (wr_data_q[2:0])
            3'b000, 3'b001, 3'b010, 3'b100: mode_ok = 1'b1;
            default:                        mode_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow      <= '0;
            active      <= '0;
            mode        <= 3'b000;
            mode_stm    <= 1'b0;
            mode_afm_tp <= 1'b0;
            mode_afm_cn <= 1'b0;
            err         <= 1'b0;
            pending     <= 1'b0;
            upd_pulse   <= 1'b0;
        end else begin
            upd_pulse <= 1'b0;
            if (wr_stb) begin
                for (int k = 0; k < NCH; k++) begin
                    if (wr_addr_q == ADDR_W'(k)) begin
                        shadow[k] <= wr_data_q;
                        pending   <= 1'b1;
                    end
                end
                if (wr_addr_q == ADDR_MODE) begin
                    if (mode_ok) begin
                        mode        <= wr_data_q[2:0];
                        mode_stm    <= (wr_data_q[2:0] == 3'b001);
                        mode_afm_tp <= (wr_data_q[2:0] == 3'b010);
                        mode_afm_cn <= (wr_data_q[2:0] == 3'b100);
                    end else begin
                        err <= 1'b1;
                    end
                end
                if (wr_addr_q == ADDR_COMMIT) begin
                    active    <= shadow;
                    pending   <= 1'b0;
                    upd_pulse <= 1'b1;
                end
                if (wr_addr_q == ADDR_CLRERR) begin
                    err <= 1'b0;
                end
            end
        end
    end

    assign pid_gain = active;
    assign bus_oe   = ~bus_rd_n;

    always_comb begin
        bus_dout = '0;
        if (!bus_rd_n) begin
            for (int k = 0; k < NCH; k++) begin
                if (bus_addr == ADDR_W'(k)) begin
                    bus_dout = shadow[k];
                end
            end
            if (bus_addr == ADDR_MODE) begin
                bus_dout = DATA_W'(mode);
            end
            if (bus_addr == ADDR_STATUS) begin
                bus_dout = DATA_W'({err, pending, mode});
            end
        end
    end

endmodule

// File: tb/tb_cpld_pid_regfile.sv
// tb/tb_cpld_pid_regfile.sv - directed bench for cpld_pid_regfile
`timescale 1ns/1ps
module tb_cpld_pid_regfile;

    logic        clk;
    logic        rst;
    logic [3:0]  bus_addr;
    logic [7:0]  bus_din;
    logic        bus_wr_n;
    logic        bus_rd_n;
    logic [7:0]  bus_dout;
    logic        bus_oe;
    logic [15:0] pid_gain;
    logic        mode_stm, mode_afm_tp, mode_afm_cn;
    logic        upd_pulse;

    logic [3:0]  bus_addr2;
    logic [11:0] bus_din2;
    logic        bus_wr2_n;
    logic        bus_rd2_n;
    logic [11:0] bus_dout2;
    logic        bus_oe2;
    logic [47:0] pid_gain2;
    logic        m2_stm, m2_tp, m2_cn;
    logic        upd_pulse2;

    int tests;
    int fails;
    int upd_cnt;
    int excl_err;

    cpld_pid_regfile dut (
        .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_din(bus_din),
        .bus_wr_n(bus_wr_n), .bus_rd_n(bus_rd_n), .bus_dout(bus_dout), .bus_oe(bus_oe),
        .pid_gain(pid_gain), .mode_stm(mode_stm), .mode_afm_tp(mode_afm_tp),
        .mode_afm_cn(mode_afm_cn), .upd_pulse(upd_pulse)
    );

    cpld_pid_regfile #(.DATA_W(12), .NCH(4), .ADDR_W(4)) dut_wide (
        .clk(clk), .rst(rst), .bus_addr(bus_addr2), .bus_din(bus_din2),
        .bus_wr_n(bus_wr2_n), .bus_rd_n(bus_rd2_n), .bus_dout(bus_dout2), .bus_oe(bus_oe2),
        .pid_gain(pid_gain2), .mode_stm(m2_stm), .mode_afm_tp(m2_tp),
        .mode_afm_cn(m2_cn), .upd_pulse(upd_pulse2)
    );

    initial clk = 1'b0;
    always #500 clk = ~clk;

    always @(negedge clk) begin
        if (upd_pulse) upd_cnt++;
        if ($countones({mode_stm, mode_afm_tp, mode_afm_cn}) > 1) excl_err++;
    end

    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        bus_addr = a;
        bus_din  = d;
        bus_wr_n = 1'b0;
        repeat (3) @(negedge clk);
        bus_wr_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic bus_write2(input logic [3:0] a, input logic [11:0] d);
        @(negedge clk);
        bus_addr2 = a;
        bus_din2  = d;
        bus_wr2_n = 1'b0;
        repeat (3) @(negedge clk);
        bus_wr2_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
        bus_addr = a;
        bus_rd_n = 1'b0;
        #1;
        d = bus_dout;
        bus_rd_n = 1'b1;
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] d;
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests++;
        if (pid_gain !== 16'h0000 || upd_pulse !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: pid_gain=%h upd=%b, want 0000 0", pid_gain, upd_pulse);
        end
        tests++;
        if ({mode_stm, mode_afm_tp, mode_afm_cn} !== 3'b000) begin
            fails++;
            $display("FAIL reset_modes: got %b want 000", {mode_stm, mode_afm_tp, mode_afm_cn});
        end
        bus_read(4'hE, d);
        tests++;
        if (d !== 8'h00) begin
            fails++;
            $display("FAIL reset_status: got %h want 00", d);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_shadow();
        logic [7:0] d;
        int c0;
        c0 = upd_cnt;
        bus_write(4'h0, 8'h5A);
        bus_write(4'h1, 8'h3C);
        tests++;
        if (pid_gain !== 16'h0000) begin
            fails++;
            $display("FAIL shadow_no_commit: pid_gain=%h want 0000", pid_gain);
        end
        bus_read(4'hE, d);
        tests++;
        if (d !== 8'h08) begin
            fails++;
            $display("FAIL shadow_status: got %h want 08", d);
        end
        bus_read(4'h0, d);
        tests++;
        if (d !== 8'h5A) begin
            fails++;
            $display("FAIL shadow0_read: got %h want 5a", d);
        end
        bus_read(4'h1, d);
        tests++;
        if (d !== 8'h3C) begin
            fails++;
            $display("FAIL shadow1_read: got %h want 3c", d);
        end
        tests++;
        if (upd_cnt !== c0) begin
            fails++;
            $display("FAIL shadow_no_pulse: pulses=%0d want 0", upd_cnt - c0);
        end
    endtask

    task automatic test_commit();
        logic [7:0] d;
        int c0;
        c0 = upd_cnt;
        @(negedge clk);
        bus_addr = 4'hD;
        bus_din  = 8'h00;
        bus_wr_n = 1'b0;
        repeat (3) @(negedge clk);
        bus_wr_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (pid_gain !== 16'h0000 || upd_pulse !== 1'b0) begin
            fails++;
            $display("FAIL commit_early: after 3rd edge pid_gain=%h upd=%b want 0000 0", pid_gain, upd_pulse);
        end
        @(posedge clk);
        #1;
        tests++;
        if (pid_gain !== 16'h3C5A || upd_pulse !== 1'b1) begin
            fails++;
            $display("FAIL commit_edge: pid_gain=%h upd=%b want 3c5a 1", pid_gain, upd_pulse);
        end
        @(posedge clk);
        #1;
        tests++;
        if (upd_pulse !== 1'b0) begin
            fails++;
            $display("FAIL commit_pulse_width: upd=%b want 0", upd_pulse);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (upd_cnt - c0 !== 1) begin
            fails++;
            $display("FAIL commit_pulse_count: got %0d want 1", upd_cnt - c0);
        end
        bus_read(4'hE, d);
        tests++;
        if (d !== 8'h00) begin
            fails++;
            $display("FAIL commit_status: got %h want 00", d);
        end
    endtask

    task automatic test_commit_nopending();
        int c0;
        c0 = upd_cnt;
        bus_write(4'h1, 8'h11);
        bus_write(4'hD, 8'hFF);
        bus_write(4'hD, 8'h00);
        tests++;
        if (pid_gain !== 16'h115A || upd_cnt - c0 !== 2) begin
            fails++;
            $display("FAIL commit_nopending: pid_gain=%h pulses=%0d want 115a 2", pid_gain, upd_cnt - c0);
        end
    endtask

    task automatic test_mode();
        logic [7:0] d;
        bus_write(4'hC, 8'h02);
        tests++;
        if ({mode_stm, mode_afm_tp, mode_afm_cn} !== 3'b010) begin
            fails++;
            $display("FAIL mode_tp: got %b want 010", {mode_stm, mode_afm_tp, mode_afm_cn});
        end
        bus_write(4'hC, 8'h05);
        bus_read(4'hE, d);
        tests++;
        if (d !== 8'h12 || mode_afm_tp !== 1'b1) begin
            fails++;
            $display("FAIL mode_invalid: status=%h tp=%b want 12 1", d, mode_afm_tp);
        end
        bus_write(4'hF, 8'h00);
        bus_read(4'hE, d);
        tests++;
        if (d !== 8'h02) begin
            fails++;
            $display("FAIL mode_clear: status=%h want 02", d);
        end
        bus_write(4'hC, 8'hF9);
        bus_read(4'hC, d);
        tests++;
        if (d !== 8'h01 || {mode_stm, mode_afm_tp, mode_afm_cn} !== 3'b100) begin
            fails++;
            $display("FAIL mode_high_bits: read=%h modes=%b want 01 100", d, {mode_stm, mode_afm_tp, mode_afm_cn});
        end
        bus_write(4'hC, 8'h04);
        tests++;
        if ({mode_stm, mode_afm_tp, mode_afm_cn} !== 3'b001) begin
            fails++;
            $display("FAIL mode_cn: got %b want 001", {mode_stm, mode_afm_tp, mode_afm_cn});
        end
        bus_write(4'hC, 8'h07);
        bus_write(4'hF, 8'h00);
        bus_read(4'hE, d);
        tests++;
        if (d !== 8'h04) begin
            fails++;
            $display("FAIL mode_inval_then_clr: status=%h want 04", d);
        end
        bus_write(4'hF, 8'h00);
        bus_write(4'hC, 8'h03);
        bus_read(4'hE, d);
        tests++;
        if (d !== 8'h14) begin
            fails++;
            $display("FAIL mode_clr_then_inval: status=%h want 14", d);
        end
        bus_write(4'hC, 8'h00);
        bus_write(4'hF, 8'h00);
        tests++;
        if ({mode_stm, mode_afm_tp, mode_afm_cn} !== 3'b000) begin
            fails++;
            $display("FAIL mode_off: got %b want 000", {mode_stm, mode_afm_tp, mode_afm_cn});
        end
    endtask

    task automatic test_unmapped();
        logic [7:0] d;
        bus_write(4'h7, 8'hA5);
        bus_addr = 4'h7;
        bus_rd_n = 1'b0;
        #1;
        tests++;
        if (bus_dout !== 8'h00 || bus_oe !== 1'b1) begin
            fails++;
            $display("FAIL unmapped_read: dout=%h oe=%b want 00 1", bus_dout, bus_oe);
        end
        bus_addr = 4'h0;
        #1;
        tests++;
        if (bus_dout !== 8'h5A) begin
            fails++;
            $display("FAIL read_comb_mux: dout=%h want 5a", bus_dout);
        end
        bus_rd_n = 1'b1;
        #1;
        tests++;
        if (bus_dout !== 8'h00 || bus_oe !== 1'b0) begin
            fails++;
            $display("FAIL read_idle: dout=%h oe=%b want 00 0", bus_dout, bus_oe);
        end
        bus_read(4'hD, d);
        tests++;
        if (d !== 8'h00) begin
            fails++;
            $display("FAIL read_commit_addr: got %h want 00", d);
        end
        bus_read(4'hE, d);
        tests++;
        if (d !== 8'h00) begin
            fails++;
            $display("FAIL unmapped_no_side_effect: status=%h want 00", d);
        end
    endtask

    task automatic test_reset_during_write();
        logic [7:0] d;
        int c0;
        apply_reset();
        c0 = upd_cnt;
        // Strobe rises while reset is held: the write must vanish
        @(negedge clk);
        bus_addr = 4'h1;
        bus_din  = 8'h77;
        bus_wr_n = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bus_wr_n = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        bus_read(4'h1, d);
        tests++;
        if (d !== 8'h00) begin
            fails++;
            $display("FAIL rst_discard: shadow1=%h want 00", d);
        end
        // Strobe rises after reset release: the write is honoured
        @(negedge clk);
        bus_addr = 4'h0;
        bus_din  = 8'hFF;
        bus_wr_n = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        bus_wr_n = 1'b1;
        repeat (6) @(negedge clk);
        bus_read(4'h0, d);
        tests++;
        if (d !== 8'hFF) begin
            fails++;
            $display("FAIL rst_then_write: shadow0=%h want ff", d);
        end
        bus_read(4'hE, d);
        tests++;
        if (d !== 8'h08 || pid_gain !== 16'h0000) begin
            fails++;
            $display("FAIL rst_then_write_state: status=%h pid_gain=%h want 08 0000", d, pid_gain);
        end
        tests++;
        if (upd_cnt !== c0 || {mode_stm, mode_afm_tp, mode_afm_cn} !== 3'b000) begin
            fails++;
            $display("FAIL rst_then_write_quiet: pulses=%0d modes=%b want 0 000", upd_cnt - c0, {mode_stm, mode_afm_tp, mode_afm_cn});
        end
    endtask

    task automatic test_wide();
        bus_write2(4'h3, 12'hABC);
        tests++;
        if (pid_gain2 !== 48'h0) begin
            fails++;
            $display("FAIL wide_no_commit: pid_gain=%h want 0", pid_gain2);
        end
        bus_write2(4'hD, 12'h000);
        tests++;
        if (pid_gain2 !== 48'hABC_000_000_000) begin
            fails++;
            $display("FAIL wide_commit: pid_gain=%h want abc000000000", pid_gain2);
        end
        bus_addr2 = 4'h3;
        bus_rd2_n = 1'b0;
        #1;
        tests++;
        if (bus_dout2 !== 12'hABC || bus_oe2 !== 1'b1) begin
            fails++;
            $display("FAIL wide_read: dout=%h oe=%b want abc 1", bus_dout2, bus_oe2);
        end
        bus_rd2_n = 1'b1;
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        upd_cnt   = 0;
        excl_err  = 0;
        rst       = 1'b1;
        bus_addr  = 4'h0;
        bus_din   = 8'h00;
        bus_wr_n  = 1'b1;
        bus_rd_n  = 1'b1;
        bus_addr2 = 4'h0;
        bus_din2  = 12'h000;
        bus_wr2_n = 1'b1;
        bus_rd2_n = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        test_reset();
        test_shadow();
        test_commit();
        test_commit_nopending();
        test_mode();
        test_unmapped();
        test_reset_during_write();
        test_wide();

        tests++;
        if (excl_err !== 0) begin
            fails++;
            $display("FAIL mode_exclusive: %0d cycles with multiple modes, want 0", excl_err);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
